// File: rtl/apb4_cpuif_bridge.sv
// apb4_cpuif_bridge
// APB4 slave front end for the register-block cpuif. One transfer is in
// flight at a time. The bridge respects cpuif stalls, accepts only acks of
// the request direction, rejects misaligned addresses, and times out silent
// accesses with PSLVERR. All APB response outputs come straight from flops.
module apb4_cpuif_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit ALIGN_CHECK    = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [2:0]              pprot_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic                    pready_o,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pslverr_o,
  output logic                    cpuif_req_o,
  output logic                    cpuif_req_is_wr_o,
  output logic [ADDR_WIDTH-1:0]   cpuif_addr_o,
  output logic [DATA_WIDTH-1:0]   cpuif_wr_data_o,
  output logic [DATA_WIDTH-1:0]   cpuif_wr_biten_o,
  input  logic                    cpuif_req_stall_wr_i,
  input  logic                    cpuif_req_stall_rd_i,
  input  logic                    cpuif_rd_ack_i,
  input  logic                    cpuif_rd_err_i,
  input  logic [DATA_WIDTH-1:0]   cpuif_rd_data_i,
  input  logic                    cpuif_wr_ack_i,
  input  logic                    cpuif_wr_err_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // The counter only has to reach TIMEOUT_CYCLES-1: expiry is decided in that cycle.
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN      = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0]  TO_LAST    =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Byte strobes become bit enables, one strobe per 8 data bits.
  function automatic logic [DATA_WIDTH-1:0] expand_strb(input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] biten;
    biten = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      biten[i*8 +: 8] = {8{strb[i]}};
    end
    return biten;
  endfunction

  state_t                  state_q;
  logic                    is_wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   biten_q;
  logic [CNT_WIDTH-1:0]    to_cnt_q;
  logic [CNT_WIDTH-1:0]    to_cnt_d;
  logic                    pready_q;
  logic                    pslverr_q;
  logic [DATA_WIDTH-1:0]   prdata_q;

  logic                    stall_s;
  logic                    ack_s;
  logic                    ack_err_s;
  logic [DATA_WIDTH-1:0]   ack_data_s;
  logic                    expire_s;
  logic                    misalign_s;
  logic                    unused_s;

  // Select the stall/ack/err/data of the captured direction; the other direction is ignored.
  always_comb begin
    stall_s    = is_wr_q ? cpuif_req_stall_wr_i : cpuif_req_stall_rd_i;
    ack_s      = is_wr_q ? cpuif_wr_ack_i : cpuif_rd_ack_i;
    ack_err_s  = is_wr_q ? cpuif_wr_err_i : cpuif_rd_err_i;
    ack_data_s = is_wr_q ? {DATA_WIDTH{1'b0}} : cpuif_rd_data_i;
    expire_s   = TO_EN && (to_cnt_q == TO_LAST);
    to_cnt_d   = to_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    misalign_s = ALIGN_CHECK && ((paddr_i & ALIGN_MASK) != {ADDR_WIDTH{1'b0}});
  end

  // Protection bits are reserved and intentionally unused.
  assign unused_s = ^pprot_i;

  // Transfer FSM; APB response flops are loaded on entry to RESP and cleared elsewhere.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      biten_q   <= '0;
      to_cnt_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          if (psel_i && !penable_i) begin
            is_wr_q  <= pwrite_i;
            addr_q   <= paddr_i;
            wdata_q  <= pwdata_i;
            biten_q  <= pwrite_i ? expand_strb(pstrb_i) : {DATA_WIDTH{1'b0}};
            to_cnt_q <= '0;
            if (misalign_s) begin
              state_q   <= ST_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
            end else begin
              state_q <= ST_ISSUE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (!psel_i) begin
            state_q <= ST_IDLE;
          end else if (!stall_s && ack_s) begin
            state_q   <= ST_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= ack_err_s;
            prdata_q  <= ack_data_s;
          end else if (expire_s) begin
            state_q   <= ST_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
          end else begin
            to_cnt_q <= to_cnt_d;
            state_q  <= stall_s ? ST_ISSUE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!psel_i) begin
            state_q <= ST_IDLE;
          end else if (ack_s) begin
            state_q   <= ST_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= ack_err_s;
            prdata_q  <= ack_data_s;
          end else if (expire_s) begin
            state_q   <= ST_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
          end else begin
            to_cnt_q <= to_cnt_d;
            state_q  <= ST_WAIT;
          end
        end
        ST_RESP: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= ST_IDLE;
        end
        default: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign pready_o          = pready_q;
  assign pslverr_o         = pslverr_q;
  assign prdata_o          = prdata_q;
  assign cpuif_req_o       = (state_q == ST_ISSUE) && !stall_s;
  assign cpuif_req_is_wr_o = is_wr_q;
  assign cpuif_addr_o      = addr_q;
  assign cpuif_wr_data_o   = wdata_q;
  assign cpuif_wr_biten_o  = biten_q;

endmodule

// File: tb/tb_apb4_cpuif_bridge.sv
// Testbench for apb4_cpuif_bridge: directed APB transfers with expected
// cpuif requests and APB responses queued by the driver and checked by a
// negedge monitor.
module tb_apb4_cpuif_bridge;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int WATCHDOG = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [2:0]    pprot = 3'b010;
  logic [DW-1:0] pwdata = '0;
  logic [SW-1:0] pstrb = '0;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;
  logic          req, req_is_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_biten;
  logic          stall_wr = 1'b0, stall_rd = 1'b0;
  logic          rd_ack = 1'b0, rd_err = 1'b0, wr_ack = 1'b0, wr_err = 1'b0;
  logic [DW-1:0] rd_data = '0;

  apb4_cpuif_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8), .ALIGN_CHECK(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .paddr_i(paddr),
    .pprot_i(pprot), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
    .cpuif_req_o(req), .cpuif_req_is_wr_o(req_is_wr), .cpuif_addr_o(req_addr),
    .cpuif_wr_data_o(req_wdata), .cpuif_wr_biten_o(req_biten),
    .cpuif_req_stall_wr_i(stall_wr), .cpuif_req_stall_rd_i(stall_rd),
    .cpuif_rd_ack_i(rd_ack), .cpuif_rd_err_i(rd_err), .cpuif_rd_data_i(rd_data),
    .cpuif_wr_ack_i(wr_ack), .cpuif_wr_err_i(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic [31:0]   cyc;
  } resp_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] biten;
    logic [31:0]   cyc;
  } req_t;

  resp_t resp_q[$];
  req_t  req_q[$];
  int    cyc = 0;
  bit    done = 1'b0;
  int    checks = 0;
  int    failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reset values, scoreboarded requests/responses, end and watchdog checks.
  always @(negedge clk) begin
    resp_t r;
    req_t  q;
    if (rst) begin
      chk("rst_pready",    64'(pready),    64'h0);
      chk("rst_pslverr",   64'(pslverr),   64'h0);
      chk("rst_prdata",    64'(prdata),    64'h0);
      chk("rst_req",       64'(req),       64'h0);
      chk("rst_req_is_wr", 64'(req_is_wr), 64'h0);
      chk("rst_addr",      64'(req_addr),  64'h0);
      chk("rst_wdata",     64'(req_wdata), 64'h0);
      chk("rst_biten",     64'(req_biten), 64'h0);
    end else begin
      if (pready) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_pready", 64'(pready), 64'h0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_cycle",   64'(cyc),     64'(r.cyc));
          chk("resp_prdata",  64'(prdata),  64'(r.data));
          chk("resp_pslverr", 64'(pslverr), 64'(r.err));
        end
      end else begin
        chk("idle_resp_zero", 64'({pslverr, prdata}), 64'h0);
      end
      if (req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 64'(req), 64'h0);
        end else begin
          q = req_q.pop_front();
          chk("req_cycle", 64'(cyc),       64'(q.cyc));
          chk("req_is_wr", 64'(req_is_wr), 64'(q.wr));
          chk("req_addr",  64'(req_addr),  64'(q.addr));
          chk("req_wdata", 64'(req_wdata), 64'(q.wdata));
          chk("req_biten", 64'(req_biten), 64'(q.biten));
        end
      end
    end
    if (done || cyc > WATCHDOG) begin
      chk("watchdog_done", 64'(done), 64'h1);
      chk("resp_q_left", 64'(resp_q.size()), 64'h0);
      chk("req_q_left",  64'(req_q.size()),  64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
  endtask

  // Setup phase in T0, access phase from T1; returns with time inside T1.
  task automatic start(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, output int t0);
    nxt();
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    t0 = cyc;
    nxt();
    penable = 1'b1;
  endtask

  task automatic exp_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] b, input int c);
    req_q.push_back('{wr: wr, addr: a, wdata: d, biten: b, cyc: 32'(c)});
  endtask

  task automatic exp_resp(input logic [DW-1:0] d, input logic e, input int c);
    resp_q.push_back('{data: d, err: e, cyc: 32'(c)});
  endtask

  initial begin
    int t;
    repeat (3) nxt();
    rst = 1'b0;

    // Write, wr_ack one cycle after req: strobes 0101 -> 00FF00FF.
    start(1'b1, 8'h04, 32'hDEADBEEF, 4'b0101, t);
    exp_req(1'b1, 8'h04, 32'hDEADBEEF, 32'h00FF00FF, t + 1);
    exp_resp(32'h0, 1'b0, t + 3);
    nxt(); wr_ack = 1'b1;
    nxt(); wr_ack = 1'b0;
    nxt(); bus_idle();

    // Read with combinational rd_ack in the req cycle.
    start(1'b0, 8'h08, 32'h0, 4'h0, t);
    exp_req(1'b0, 8'h08, 32'h0, 32'h0, t + 1);
    exp_resp(32'h12345678, 1'b0, t + 2);
    rd_ack = 1'b1; rd_data = 32'h12345678;
    nxt(); rd_ack = 1'b0; rd_data = '0;
    nxt(); bus_idle();

    // Write stalled for 5 cycles while stall_rd toggles.
    stall_wr = 1'b1;
    start(1'b1, 8'h10, 32'hA5A55A5A, 4'hF, t);
    exp_req(1'b1, 8'h10, 32'hA5A55A5A, 32'hFFFFFFFF, t + 6);
    exp_resp(32'h0, 1'b0, t + 7);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) nxt();
      stall_rd = ~stall_rd;
    end
    nxt(); stall_wr = 1'b0; stall_rd = ~stall_rd; wr_ack = 1'b1;
    nxt(); wr_ack = 1'b0; stall_rd = ~stall_rd;
    nxt(); bus_idle(); stall_rd = 1'b0;

    // Read with no ack: timeout after 8 cycles, late rd_ack ignored.
    start(1'b0, 8'h20, 32'h0, 4'h0, t);
    exp_req(1'b0, 8'h20, 32'h0, 32'h0, t + 1);
    exp_resp(32'h0, 1'b1, t + 9);
    repeat (8) nxt();
    nxt(); bus_idle(); rd_ack = 1'b1; rd_data = 32'hFFFFFFFF;
    nxt(); rd_ack = 1'b0; rd_data = '0;

    // Misaligned address: error at T1, no request.
    start(1'b1, 8'h06, 32'h01020304, 4'hF, t);
    exp_resp(32'h0, 1'b1, t + 1);
    nxt(); bus_idle();

    // Read: wrong-direction ack ignored, then rd_ack with rd_err.
    start(1'b0, 8'h0C, 32'h0, 4'h0, t);
    exp_req(1'b0, 8'h0C, 32'h0, 32'h0, t + 1);
    exp_resp(32'hCAFE0001, 1'b1, t + 4);
    nxt(); wr_ack = 1'b1; wr_err = 1'b1;
    nxt(); wr_ack = 1'b0; wr_err = 1'b0; rd_ack = 1'b1; rd_err = 1'b1; rd_data = 32'hCAFE0001;
    nxt(); rd_ack = 1'b0; rd_err = 1'b0; rd_data = '0;
    nxt(); bus_idle();

    // Reset asserted while in WAIT: no response.
    start(1'b1, 8'h14, 32'h11223344, 4'b0011, t);
    exp_req(1'b1, 8'h14, 32'h11223344, 32'h0000FFFF, t + 1);
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; bus_idle();

    // Normal read after reset, then back-to-back write with strobe 1000.
    start(1'b0, 8'h18, 32'h0, 4'h0, t);
    exp_req(1'b0, 8'h18, 32'h0, 32'h0, t + 1);
    exp_resp(32'h0BADF00D, 1'b0, t + 2);
    rd_ack = 1'b1; rd_data = 32'h0BADF00D;
    nxt(); rd_ack = 1'b0; rd_data = '0;
    start(1'b1, 8'h1C, 32'h87654321, 4'b1000, t);
    exp_req(1'b1, 8'h1C, 32'h87654321, 32'hFF000000, t + 1);
    exp_resp(32'h0, 1'b0, t + 2);
    wr_ack = 1'b1;
    nxt(); wr_ack = 1'b0;
    nxt(); bus_idle();

    // psel dropped in WAIT: no response, later ack ignored, bridge recovers.
    start(1'b0, 8'h24, 32'h0, 4'h0, t);
    exp_req(1'b0, 8'h24, 32'h0, 32'h0, t + 1);
    nxt(); bus_idle();
    nxt(); rd_ack = 1'b1; rd_data = 32'hDEADDEAD;
    nxt(); rd_ack = 1'b0; rd_data = '0;
    start(1'b0, 8'h28, 32'h0, 4'h0, t);
    exp_req(1'b0, 8'h28, 32'h0, 32'h0, t + 1);
    exp_resp(32'h5555AAAA, 1'b0, t + 2);
    rd_ack = 1'b1; rd_data = 32'h5555AAAA;
    nxt(); rd_ack = 1'b0; rd_data = '0;
    nxt(); bus_idle();

    repeat (3) nxt();
    done = 1'b1;
  end

endmodule
